// File: rtl/io_read_port_ready_pkg.sv
// Shared constants and elaboration helpers for the I/O read port and its
// thread counter.
package io_read_port_ready_pkg;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // Number of address bits needed to select one of 'value' items.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned remaining;
        result    = 0;
        remaining = (value > 0) ? value - 1 : 0;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/io_thread_counter.sv
// Round-robin barrel-thread counter: THREAD_INIT after reset, then steps
// 0..THREAD_COUNT-1 each cycle and wraps on an equality compare.
module io_thread_counter
    import io_read_port_ready_pkg::*;
#(
    parameter int unsigned THREAD_COUNT      = 8,
    parameter int unsigned THREAD_ADDR_WIDTH = 3,
    parameter int unsigned THREAD_INIT       = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic [THREAD_ADDR_WIDTH-1:0] thread
);

    localparam logic [THREAD_ADDR_WIDTH-1:0] LAST_THREAD = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);
    localparam logic [THREAD_ADDR_WIDTH-1:0] INIT_THREAD = THREAD_ADDR_WIDTH'(THREAD_INIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            thread <= INIT_THREAD;
        end else if (thread == LAST_THREAD) begin
            thread <= '0;
        end else begin
            thread <= thread + 1'b1;
        end
    end

endmodule

// File: rtl/io_read_port_ready.sv
// Per-thread single-word read port: an external producer fills a thread's
// slot, and that thread's read either consumes it (IO_ready) or stalls.
module io_read_port_ready
    import io_read_port_ready_pkg::*;
#(
    parameter int unsigned WORD_WIDTH        = 36,
    parameter int unsigned THREAD_COUNT      = 8,
    parameter int unsigned THREAD_ADDR_WIDTH = 3,
    parameter int unsigned THREAD_INIT       = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         rden,
    input  logic                         ext_wren,
    input  logic [THREAD_ADDR_WIDTH-1:0] ext_thread,
    input  logic [WORD_WIDTH-1:0]        ext_data,
    output logic                         ext_ready,
    output logic                         IO_ready,
    output logic [WORD_WIDTH-1:0]        rdata,
    output logic [THREAD_COUNT-1:0]      full_flags
);

    if (clog2(THREAD_COUNT) > THREAD_ADDR_WIDTH) begin : g_bad_thread_params
        $error("THREAD_COUNT does not fit in THREAD_ADDR_WIDTH bits");
    end

    localparam logic [THREAD_ADDR_WIDTH:0] COUNT_EXT = (THREAD_ADDR_WIDTH + 1)'(THREAD_COUNT);

    logic [THREAD_ADDR_WIDTH-1:0] thread;
    logic [WORD_WIDTH-1:0]        slots [THREAD_COUNT];
    logic [THREAD_COUNT-1:0]      flags;
    logic [THREAD_COUNT-1:0]      flags_next;
    logic                         ext_in_range;
    logic                         write_accept;
    logic                         read_hit;

    io_thread_counter #(
        .THREAD_COUNT      (THREAD_COUNT),
        .THREAD_ADDR_WIDTH (THREAD_ADDR_WIDTH),
        .THREAD_INIT       (THREAD_INIT)
    ) u_thread_counter (
        .clock  (clock),
        .reset  (reset),
        .thread (thread)
    );

    assign ext_in_range = ({1'b0, ext_thread} < COUNT_EXT);
    assign ext_ready    = ext_in_range && !flags[ext_thread];
    assign write_accept = ext_wren && ext_ready;
    assign read_hit     = rden && flags[thread];
    assign full_flags   = flags;

    // A same-slot collision never needs both updates: a full slot refuses the
    // write, an empty slot stalls the read, so applying both in order is safe.
    always_comb begin
        flags_next = flags;
        if (read_hit) begin
            flags_next[thread] = LOW;
        end
        if (write_accept) begin
            flags_next[ext_thread] = HIGH;
        end
    end

    always_ff @(posedge clock) begin
        if (write_accept) begin
            slots[ext_thread] <= ext_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags    <= '0;
            IO_ready <= LOW;
            rdata    <= '0;
        end else begin
            flags <= flags_next;
            if (!rden) begin
                IO_ready <= HIGH;
            end else if (read_hit) begin
                IO_ready <= HIGH;
                rdata    <= slots[thread];
            end else begin
                IO_ready <= LOW;
            end
        end
    end

endmodule

// File: tb/tb_io_read_port_ready.sv
// Scoreboard bench for io_read_port_ready: a reference model pushes the
// expected registered outputs per cycle, popped and compared a cycle later.
module tb_io_read_port_ready;

    localparam int unsigned WW = 36;
    localparam int unsigned TC = 8;
    localparam int unsigned TW = 3;
    localparam int unsigned TI = 0;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rden = 1'b0;
    logic          ext_wren = 1'b0;
    logic [TW-1:0] ext_thread = '0;
    logic [WW-1:0] ext_data = '0;
    logic          ext_ready;
    logic          IO_ready;
    logic [WW-1:0] rdata;
    logic [TC-1:0] full_flags;

    io_read_port_ready #(
        .WORD_WIDTH        (WW),
        .THREAD_COUNT      (TC),
        .THREAD_ADDR_WIDTH (TW),
        .THREAD_INIT       (TI)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rden       (rden),
        .ext_wren   (ext_wren),
        .ext_thread (ext_thread),
        .ext_data   (ext_data),
        .ext_ready  (ext_ready),
        .IO_ready   (IO_ready),
        .rdata      (rdata),
        .full_flags (full_flags)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          io_ready;
        logic [WW-1:0] rdata;
        logic [TC-1:0] flags;
    } exp_t;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int unsigned m_thread;
    logic [TC-1:0] m_flags;
    logic [WW-1:0] m_slot [TC];
    logic [WW-1:0] m_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_thread = TI;
        m_flags  = '0;
        m_rdata  = '0;
        sb.delete();
    endtask

    // Entered just after a falling edge; drives one cycle and checks its result.
    task automatic cycle(input logic rd, input logic wr, input int unsigned wt, input logic [WW-1:0] wd);
        exp_t e;
        logic acc;
        rden       = rd;
        ext_wren   = wr;
        ext_thread = TW'(wt);
        ext_data   = wd;
        #1;
        check("ext_ready", 64'(ext_ready), 64'(!m_flags[wt]));
        acc = wr && !m_flags[wt];
        if (rd && m_flags[m_thread]) begin
            m_rdata = m_slot[m_thread];
            m_flags[m_thread] = 1'b0;
            e.io_ready = 1'b1;
        end else begin
            e.io_ready = !rd;
        end
        if (acc) begin
            m_slot[wt]  = wd;
            m_flags[wt] = 1'b1;
        end
        e.rdata = m_rdata;
        e.flags = m_flags;
        sb.push_back(e);
        @(posedge clock);
        m_thread = (m_thread == TC - 1) ? 0 : m_thread + 1;
        @(negedge clock);
        rden     = 1'b0;
        ext_wren = 1'b0;
        if (sb.size() == 0) begin
            check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check("IO_ready", 64'(IO_ready), 64'(e.io_ready));
            check("rdata", 64'(rdata), 64'(e.rdata));
            check("full_flags", 64'(full_flags), 64'(e.flags));
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, '0);
    endtask

    task automatic write(input int unsigned wt, input logic [WW-1:0] wd);
        cycle(1'b0, 1'b1, wt, wd);
    endtask

    // Bounded: the model thread reaches any slot within TC idle cycles.
    task automatic go_thread(input int unsigned t);
        for (int i = 0; i < int'(TC) && m_thread != t; i++) idle();
        check("go_thread", 64'(m_thread), 64'(t));
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_IO_ready", 64'(IO_ready), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_flags", 64'(full_flags), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Idle run across two counter wraps.
        for (int i = 0; i < 16; i++) idle();

        // Fill thread 3, then consume it on its own turn.
        write(3, 36'h123);
        go_thread(3);
        cycle(1'b1, 1'b0, 0, '0);

        // Thread 5 empty: stall on four turns, fill, then consume.
        go_thread(5);
        cycle(1'b1, 1'b0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            go_thread(5);
            cycle(1'b1, 1'b0, 0, '0);
        end
        write(5, 36'hA_5A5A_5A5A);
        go_thread(5);
        cycle(1'b1, 1'b0, 0, '0);

        // Double write to thread 2: second one refused.
        write(2, 36'h0_0000_0222);
        write(2, 36'h0_0000_0999);
        go_thread(2);
        cycle(1'b1, 1'b0, 0, '0);

        // Same-slot collision, full: old word read, new write refused.
        write(4, 36'h4_4444_0004);
        go_thread(4);
        cycle(1'b1, 1'b1, 4, 36'hF_FFFF_FFFF);
        // Same-slot collision, empty: write lands, read stalls.
        go_thread(6);
        cycle(1'b1, 1'b1, 6, 36'h6_0606_0606);
        go_thread(6);
        cycle(1'b1, 1'b0, 0, '0);

        // Different slots in the same cycle stay independent.
        write(7, 36'h7_0000_0077);
        go_thread(7);
        cycle(1'b1, 1'b1, 1, 36'h1_1111_1111);
        go_thread(1);
        cycle(1'b1, 1'b0, 0, '0);

        // Build flags 0x5A, then reset asynchronously mid-cycle.
        write(1, 36'h101);
        write(3, 36'h303);
        write(4, 36'h404);
        write(6, 36'h606);
        check("flags_5A", 64'(full_flags), 64'h5A);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_flags", 64'(full_flags), 64'd0);
        check("mid_rst_IO_ready", 64'(IO_ready), 64'd0);
        check("mid_rst_rdata", 64'(rdata), 64'd0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Counter restarts at THREAD_INIT; pending reads stall until refilled.
        go_thread(1);
        cycle(1'b1, 1'b0, 0, '0);
        write(0, 36'hC_0FFE_E000);
        go_thread(0);
        cycle(1'b1, 1'b0, 0, '0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
